// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard control for a 5-stage pipeline.
// Tracks EX/MEM/WB destination metadata and registers per-operand forwarding selects.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter bit RF_BYPASS  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  hold,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  load_use_stall
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } entry_t;

    entry_t     ex_q, ex_d;
    entry_t     mem_q, mem_d;
    entry_t     wb_q, wb_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic [1:0] match_a, match_b;
    logic       stall;
    entry_t     id_entry;

    // x0 is hardwired to zero, so a write to it is never a real producer.
    function automatic logic writes(input entry_t e, input logic [REG_ADDR_W-1:0] r);
        return e.valid && e.reg_write && (e.rd == r) && (r != '0);
    endfunction

    function automatic logic [1:0] src_code(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  uses,
        input entry_t                ex,
        input entry_t                mem,
        input entry_t                wb
    );
        logic [1:0] code;
        code = 2'b00;
        if (uses) begin
            if (writes(ex, src))
                code = 2'b01;
            else if (writes(mem, src))
                code = 2'b10;
            else if (writes(wb, src) && !RF_BYPASS)
                code = 2'b11;
        end
        return code;
    endfunction

    always_comb begin
        id_entry.valid     = id_valid;
        id_entry.rd        = id_rd;
        id_entry.reg_write = id_reg_write;
        id_entry.mem_read  = id_mem_read;
    end

    assign match_a = src_code(id_rs1, id_uses_rs1, ex_q, mem_q, wb_q);
    assign match_b = src_code(id_rs2, id_uses_rs2, ex_q, mem_q, wb_q);

    // A load in EX cannot forward until it reaches MEM, so its consumer must wait a cycle.
    assign stall = id_valid && !flush && ex_q.valid && ex_q.mem_read &&
                   ((id_uses_rs1 && writes(ex_q, id_rs1)) ||
                    (id_uses_rs2 && writes(ex_q, id_rs2)));

    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!hold) begin
            mem_d = ex_q;
            wb_d  = mem_q;
            if (flush || stall) begin
                ex_d    = '0;
                fwd_a_d = 2'b00;
                fwd_b_d = 2'b00;
            end else begin
                ex_d    = id_entry;
                fwd_a_d = id_valid ? match_a : 2'b00;
                fwd_b_d = id_valid ? match_b : 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_sel      = fwd_a_q;
    assign fwd_b_sel      = fwd_b_q;
    assign load_use_stall = stall;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (RF_BYPASS=0 and 1) driven in lockstep
// and compared against a history-based model of the in-flight instructions.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
    logic       hold, flush;
    logic [1:0] a0, b0, a1, b1;
    logic       stall0, stall1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_ADDR_W(5), .RF_BYPASS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .hold(hold), .flush(flush),
        .fwd_a_sel(a0), .fwd_b_sel(b0), .load_use_stall(stall0)
    );

    fwd_hazard_unit #(.REG_ADDR_W(5), .RF_BYPASS(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .hold(hold), .flush(flush),
        .fwd_a_sel(a1), .fwd_b_sel(b1), .load_use_stall(stall1)
    );

    // Model: hist[0] is the instruction now in EX, hist[1] in MEM, hist[2] in WB.
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } instr_t;

    instr_t hist[3];
    logic [7:0] exp_sels;   // {a0, b0, a1, b1}

    function automatic bit produces(input instr_t e, input int r);
        return e.v && e.rw && e.rd == r && r != 0;
    endfunction

    function automatic logic [1:0] model_sel(input bit uses, input int src, input bit bypass);
        if (!uses) return 2'd0;
        for (int age = 0; age < 3; age++) begin
            if (produces(hist[age], src)) begin
                if (age == 2) return bypass ? 2'd0 : 2'd3;
                return 2'(age + 1);
            end
        end
        return 2'd0;
    endfunction

    function automatic bit model_stall();
        return id_valid && !flush && hist[0].v && hist[0].mr &&
               ((id_uses_rs1 && produces(hist[0], int'(id_rs1))) ||
                (id_uses_rs2 && produces(hist[0], int'(id_rs2))));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
        exp_sels = 8'h00;
    endtask

    // Advance the model for the current inputs, then let the DUT take the same edge.
    task automatic step();
        bit st;
        st = model_stall();
        if (!hold) begin
            if (flush || st || !id_valid)
                exp_sels = 8'h00;
            else
                exp_sels = {model_sel(id_uses_rs1, int'(id_rs1), 1'b0), model_sel(id_uses_rs2, int'(id_rs2), 1'b0),
                            model_sel(id_uses_rs1, int'(id_rs1), 1'b1), model_sel(id_uses_rs2, int'(id_rs2), 1'b1)};
            hist[2] = hist[1];
            hist[1] = hist[0];
            if (flush || st)
                hist[0] = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
            else
                hist[0] = '{v: id_valid, rd: int'(id_rd), rw: id_reg_write, mr: id_mem_read};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input bit u1, input bit u2, input logic [4:0] rd,
                          input bit rw, input bit mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        model_reset();
        #1;
        checks++;
        if ({a0, b0, a1, b1, stall0, stall1} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0", {a0, b0, a1, b1, stall0, stall1});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // first instruction after reset sees no producers
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        checks++;
        if ({a0, b0, a1, b1} !== 8'h00 || exp_sels !== 8'h00) begin
            failures++;
            $display("FAIL reset_first_instr: got %h expected 00", {a0, b0, a1, b1});
        end
    endtask

    task automatic test_fwd_ex();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        checks++;
        if ({stall0, stall1} !== 2'b00) begin
            failures++;
            $display("FAIL fwd_ex_nostall: got %b expected 00", {stall0, stall1});
        end
        step();
        checks++;
        if (a0 !== 2'b01 || a1 !== 2'b01 || {a0, b0, a1, b1} !== exp_sels) begin
            failures++;
            $display("FAIL fwd_ex_sel: got %h expected %h (a=01)", {a0, b0, a1, b1}, exp_sels);
        end
    endtask

    task automatic test_fwd_mem_wb();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        step();
        checks++;
        if (b0 !== 2'b10 || b1 !== 2'b10 || {a0, b0, a1, b1} !== exp_sels) begin
            failures++;
            $display("FAIL fwd_mem_sel: got %h expected %h (b=10)", {a0, b0, a1, b1}, exp_sels);
        end
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        step();
        set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        step();
        checks++;
        if (b0 !== 2'b11 || b1 !== 2'b00 || {a0, b0, a1, b1} !== exp_sels) begin
            failures++;
            $display("FAIL fwd_wb_sel: got %h expected %h (b0=11 b1=00)", {a0, b0, a1, b1}, exp_sels);
        end
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        #1;
        checks++;
        if ({stall0, stall1} !== 2'b11 || !model_stall()) begin
            failures++;
            $display("FAIL load_use_stall: got %b expected 11", {stall0, stall1});
        end
        step();
        checks++;
        if ({stall0, stall1} !== 2'b00 || {a0, b0, a1, b1} !== 8'h00) begin
            failures++;
            $display("FAIL load_use_bubble: got stall %b sels %h expected 00/00", {stall0, stall1}, {a0, b0, a1, b1});
        end
        step();
        checks++;
        if (a0 !== 2'b10 || a1 !== 2'b10 || {a0, b0, a1, b1} !== exp_sels) begin
            failures++;
            $display("FAIL load_use_fwd: got %h expected %h (a=10)", {a0, b0, a1, b1}, exp_sels);
        end
    endtask

    task automatic test_x0_nowrite();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
        step();
        checks++;
        if ({a0, b0, a1, b1} !== 8'h00 || exp_sels !== 8'h00) begin
            failures++;
            $display("FAIL x0_reader: got %h expected 00", {a0, b0, a1, b1});
        end
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        step();
        set_id(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
        step();
        checks++;
        if ({a0, b0, a1, b1} !== 8'h00 || exp_sels !== 8'h00) begin
            failures++;
            $display("FAIL no_regwrite: got %h expected 00", {a0, b0, a1, b1});
        end
    endtask

    task automatic test_youngest();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        step();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
        step();
        checks++;
        if ({a0, b0, a1, b1} !== 8'b01010101 || exp_sels !== 8'b01010101) begin
            failures++;
            $display("FAIL youngest_wins: got %h expected 55", {a0, b0, a1, b1});
        end
    endtask

    task automatic test_flush();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        checks++;
        if ({stall0, stall1} !== 2'b00) begin
            failures++;
            $display("FAIL flush_nostall: got %b expected 00", {stall0, stall1});
        end
        step();
        flush = 1'b0;
        checks++;
        if ({a0, b0, a1, b1} !== 8'h00 || exp_sels !== 8'h00) begin
            failures++;
            $display("FAIL flush_sel: got %h expected 00", {a0, b0, a1, b1});
        end
    endtask

    task automatic test_hold();
        logic [7:0] frozen;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
        step();
        frozen = exp_sels;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'b1, 1'b1,
                   5'($urandom_range(0, 7)), 1'b1, 1'($urandom_range(0, 1)));
            flush = 1'($urandom_range(0, 1));
            step();
            checks++;
            if ({a0, b0, a1, b1} !== frozen || frozen !== 8'b01010101) begin
                failures++;
                $display("FAIL hold_frozen[%0d]: got %h expected 55", i, {a0, b0, a1, b1});
            end
        end
        hold = 1'b0;
        flush = 1'b0;
        step();
        checks++;
        if ({a0, b0, a1, b1} !== exp_sels) begin
            failures++;
            $display("FAIL hold_release: got %h expected %h", {a0, b0, a1, b1}, exp_sels);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
        #1;
        checks++;
        if ({stall0, stall1} !== 2'b11) begin
            failures++;
            $display("FAIL pre_reset_stall: got %b expected 11", {stall0, stall1});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a0, b0, a1, b1, stall0, stall1} !== 10'd0) begin
            failures++;
            $display("FAIL async_reset_stall: got %b expected 0", {a0, b0, a1, b1, stall0, stall1});
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 5) == 0);
            #1;
            checks++;
            if ({stall0, stall1} !== {2{model_stall()}}) begin
                failures++;
                $display("FAIL rand_stall[%0d]: got %b expected %b", i, {stall0, stall1}, {2{model_stall()}});
            end
            step();
            checks++;
            if ({a0, b0, a1, b1} !== exp_sels) begin
                failures++;
                $display("FAIL rand_sel[%0d]: got %h expected %h", i, {a0, b0, a1, b1}, exp_sels);
            end
        end
        hold = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd_ex();
        test_fwd_mem_wb();
        test_load_use();
        test_x0_nowrite();
        test_youngest();
        test_flush();
        test_hold();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
